// File: rtl/in_port_pkg.sv
// Shared constants for the buffered input port: status word layout and the Count width helper.
package in_port_pkg;

  localparam int ST_EMPTY    = 0;
  localparam int ST_READY    = 1;
  localparam int ST_OVF      = 2;
  localparam int ST_UDF      = 3;
  localparam int CNT_LSB     = 8;
  localparam int CNT_MSB     = 15;
  localparam int CNT_FIELD_W = CNT_MSB - CNT_LSB + 1;

  // Count must represent 0..depth inclusive, hence one bit more than a pointer.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; Count gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/in_port_fifo.sv
// Buffered first-word-fall-through input port with back-pressure, occupancy and sticky error flags.
// Optional status readback on BusMuxIn is enabled by defining IN_PORT_STATUS_EN.
module in_port_fifo
  import in_port_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                          Clock,
  input  logic                          Clear,
  input  logic                          Strobe,
  input  logic [DATA_WIDTH-1:0]         Input,
  input  logic                          RINout,
`ifdef IN_PORT_STATUS_EN
  input  logic                          StatusOut,
`endif
  output logic [DATA_WIDTH-1:0]         BusMuxIn,
  output logic                          Ready,
  output logic                          Empty,
  output logic [count_width(DEPTH)-1:0] Count,
  output logic                          Overflow,
  output logic                          Underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  logic [PTR_W-1:0]      head, tail;
  logic [DATA_WIDTH-1:0] head_word, status_word;
  logic                  status_sel, full, pop_req, do_pop, do_push, drop;

`ifdef IN_PORT_STATUS_EN
  assign status_sel = StatusOut;
`else
  assign status_sel = 1'b0;
`endif

  assign full  = (Count == CNT_W'(DEPTH));
  assign Empty = (Count == '0);
  assign Ready = !full;

  // A status read suppresses the pop entirely, including the underflow check.
  assign pop_req = RINout && !status_sel;
  assign do_pop  = pop_req && !Empty;
  assign do_push = Strobe && (!full || do_pop);
  assign drop    = Strobe && !do_push;

  fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk  (Clock),
    .we   (do_push),
    .waddr(tail),
    .wdata(Input),
    .raddr(head),
    .rdata(head_word)
  );

  // NOTE: async reset in the sensitivity list; all state updates use non-blocking assignments.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      head      <= '0;
      tail      <= '0;
      Count     <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      if (do_push) tail <= tail + PTR_W'(1);
      if (do_pop)  head <= head + PTR_W'(1);
      if (do_push && !do_pop)      Count <= Count + CNT_W'(1);
      else if (do_pop && !do_push) Count <= Count - CNT_W'(1);
      if (drop)              Overflow  <= 1'b1;
      if (pop_req && Empty)  Underflow <= 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    status_word                   = '0;
    status_word[ST_EMPTY]         = Empty;
    status_word[ST_READY]         = Ready;
    status_word[ST_OVF]           = Overflow;
    status_word[ST_UDF]           = Underflow;
    status_word[CNT_MSB:CNT_LSB]  = CNT_FIELD_W'(Count);
    if (status_sel)  BusMuxIn = status_word;
    else if (Empty)  BusMuxIn = '0;
    else             BusMuxIn = head_word;
  end

endmodule

// File: tb/tb_in_port_fifo.sv
// Self-checking bench for in_port_fifo: directed vector table, corner sequences, randomized queue model.
module tb_in_port_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          Clock, Clear, Strobe, RINout;
  logic [DW-1:0] Input;
  logic [DW-1:0] BusMuxIn;
  logic          Ready, Empty, Overflow, Underflow;
  logic [CW-1:0] Count;
`ifdef IN_PORT_STATUS_EN
  logic          StatusOut;
`endif

  in_port_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .Clock    (Clock),
    .Clear    (Clear),
    .Strobe   (Strobe),
    .Input    (Input),
    .RINout   (RINout),
`ifdef IN_PORT_STATUS_EN
    .StatusOut(StatusOut),
`endif
    .BusMuxIn (BusMuxIn),
    .Ready    (Ready),
    .Empty    (Empty),
    .Count    (Count),
    .Overflow (Overflow),
    .Underflow(Underflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, take the edge, sample 1 time unit later.
  task automatic step(input bit s, input logic [DW-1:0] d, input bit r);
    Strobe = s;
    Input  = d;
    RINout = r;
    @(posedge Clock);
    #1;
    Strobe = 1'b0;
    RINout = 1'b0;
  endtask

  task automatic do_reset();
    Clear = 1'b1;
    #1;
    check("reset_count", Count, 0);
    check("reset_bus", BusMuxIn, 0);
    @(posedge Clock);
    #1;
    Clear = 1'b0;
  endtask

  task automatic check_all(input string tag, input int ec, input logic [DW-1:0] eb,
                           input bit eo, input bit eu);
    check({tag, "_count"}, Count, ec);
    check({tag, "_bus"}, BusMuxIn, eb);
    check({tag, "_empty"}, Empty, (ec == 0));
    check({tag, "_ready"}, Ready, (ec != DEPTH));
    check({tag, "_ovf"}, Overflow, eo);
    check({tag, "_udf"}, Underflow, eu);
  endtask

  typedef struct {
    bit            strobe;
    logic [DW-1:0] data;
    bit            rinout;
    int            exp_count;
    logic [DW-1:0] exp_bus;
    bit            exp_ovf;
    bit            exp_udf;
  } vec_t;

  vec_t vecs[$];

  // Reference model: an ordered queue of stored words plus two sticky bits.
  logic [DW-1:0] q[$];
  bit            m_ovf, m_udf;

  task automatic model_step(input bit s, input logic [DW-1:0] d, input bit r);
    bit pop_ok;
    pop_ok = r && (q.size() > 0);
    if (r && q.size() == 0) m_udf = 1'b1;
    if (pop_ok) void'(q.pop_front());
    if (s) begin
      if (q.size() < DEPTH) q.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  initial begin
    Clear  = 1'b1;
    Strobe = 1'b0;
    RINout = 1'b0;
    Input  = '0;
`ifdef IN_PORT_STATUS_EN
    StatusOut = 1'b0;
`endif

    // Reset then idle.
    do_reset();
    step(0, 0, 0);
    check_all("idle", 0, 0, 0, 0);

    // Directed table: 3 push / 3 pop, then 9-word overflow fill and drain.
    vecs.push_back('{1, 32'hA5A5_0001, 0, 1, 32'hA5A5_0001, 0, 0});
    vecs.push_back('{1, 32'hA5A5_0002, 0, 2, 32'hA5A5_0001, 0, 0});
    vecs.push_back('{1, 32'hA5A5_0003, 0, 3, 32'hA5A5_0001, 0, 0});
    vecs.push_back('{0, 32'h0,         1, 2, 32'hA5A5_0002, 0, 0});
    vecs.push_back('{0, 32'h0,         1, 1, 32'hA5A5_0003, 0, 0});
    vecs.push_back('{0, 32'h0,         1, 0, 32'h0,         0, 0});
    for (int i = 1; i <= 8; i++)
      vecs.push_back('{1, 32'h100 + i, 0, i, 32'h101, 0, 0});
    vecs.push_back('{1, 32'h109, 0, 8, 32'h101, 1, 0});
    for (int i = 1; i <= 8; i++)
      vecs.push_back('{0, 32'h0, 1, 8 - i, (i == 8) ? 32'h0 : 32'h101 + i, 1, 0});
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].strobe, vecs[i].data, vecs[i].rinout);
      check_all($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_bus,
                vecs[i].exp_ovf, vecs[i].exp_udf);
    end

    // Full FIFO: simultaneous push of 0x1234 and pop.
    do_reset();
    for (int i = 1; i <= 8; i++) step(1, 32'h200 + i, 0);
    check("full_count", Count, 8);
    check("full_ready", Ready, 0);
    step(1, 32'h1234, 1);
    check("fullpp_count", Count, 8);
    check("fullpp_ovf", Overflow, 0);
    for (int i = 2; i <= 8; i++) begin
      check($sformatf("fullpp_pop%0d", i), BusMuxIn, 32'h200 + i);
      step(0, 0, 1);
    end
    check("fullpp_last", BusMuxIn, 32'h1234);
    step(0, 0, 1);
    check("fullpp_drained", Empty, 1);

    // Empty FIFO: pop and push 0xBEEF together.
    do_reset();
    step(1, 32'hBEEF, 1);
    check_all("emptypp", 1, 32'hBEEF, 0, 1);

`ifdef IN_PORT_STATUS_EN
    // Status readback with Count=3, Overflow=1; RINout must not pop.
    do_reset();
    for (int i = 0; i < 9; i++) step(1, 32'h300 + i, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    check("st_pre_count", Count, 3);
    StatusOut = 1'b1;
    RINout    = 1'b1;
    #1;
    check("st_word", BusMuxIn, 32'h0000_0306);
    @(posedge Clock);
    #1;
    StatusOut = 1'b0;
    RINout    = 1'b0;
    check("st_count_held", Count, 3);
    check("st_udf", Underflow, 0);
    check("st_bus_back", BusMuxIn, 32'h305);
`endif

    // Clear asserted mid-stream resets all outputs at once.
    do_reset();
    step(1, 32'h11, 0);
    step(1, 32'h22, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    check("pre_clear_udf", Underflow, 1);
    step(1, 32'h33, 0);
    Clear = 1'b1;
    #2;
    check_all("midclear", 0, 0, 0, 0);
    Clear = 1'b0;
    step(1, 32'h44, 0);
    check_all("postclear", 1, 32'h44, 0, 0);

    // Randomized traffic against the queue model, alternating fill-heavy and drain-heavy phases.
    do_reset();
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    for (int i = 0; i < 600; i++) begin
      bit            s, r;
      logic [DW-1:0] d;
      bit            fill_phase;
      fill_phase = ((i / 60) % 2) == 0;
      s = fill_phase ? ($urandom_range(3, 0) != 0) : ($urandom_range(3, 0) == 0);
      r = fill_phase ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0);
      d = $urandom;
      model_step(s, d, r);
      step(s, d, r);
      check_all($sformatf("rnd%0d", i), q.size(), (q.size() > 0) ? q[0] : '0, m_ovf, m_udf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/in_port_fifo.md
# in_port_fifo

Parametrised, buffered successor to the single-register input port of the Mini SRC datapath. An external device pushes words with `Strobe`. The words queue in a DEPTH-entry first-word-fall-through FIFO, and the head word is driven onto the bus mux input; the `in` instruction's `RINout` pulse pops it. The block adds back-pressure (`Ready`), occupancy reporting and sticky overflow/underflow flags, none of which the current port has.

## Interface
- `DATA_WIDTH`, 32, word width of device data and bus.
- `DEPTH`, 8, FIFO entries; power of two, >= 2.
- `Clock`  in  1  system clock; all state changes on rising edge.
- `Clear`  in  1  reset, asynchronous, active-high.
- `Strobe`  in  1  device push request; sampled on rising edge of `Clock`.
- `Input`  in  DATA_WIDTH  device data; captured with `Strobe`.
- `RINout`  in  1  bus read/pop; one pulse pops one word.
- `BusMuxIn`  out  DATA_WIDTH  head word to bus mux.
- `Ready`  out  1  FIFO not full.
- `Empty`  out  1  FIFO holds no words.
- `Count`  out  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
- `Overflow`  out  1  sticky: a push was dropped.
- `Underflow`  out  1  sticky: a pop was attempted with no data.
- `StatusOut`  in  1  present only with `IN_PORT_STATUS_EN`; see Configuration.

## Operation
- Push: `Strobe` and (not full, or pop in the same cycle) -> `Input` written at the tail; tail pointer += 1 mod DEPTH.
- Push while full with no pop: the word is dropped, storage is unchanged and `Overflow` is set.
- Pop: `RINout` and not empty -> head pointer += 1 mod DEPTH.
- Pop while empty: ignored and `Underflow` is set. A push in the same cycle is still accepted, giving Count = 1.
- Simultaneous push and pop with 0 < Count < DEPTH: Count unchanged; the new word enters behind the popped one.
- Simultaneous push and pop at Count = DEPTH: both happen; Count stays DEPTH; no overflow.
- `BusMuxIn` = mem[head] when not empty, else all zeros.
- `Ready` = (Count != DEPTH); `Empty` = (Count == 0). Both are combinational from registered Count.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is kept separately and is never derived from the pointers.
- `Overflow` and `Underflow` are cleared only by `Clear`.

## Timing
- Reset values while `Clear` is high, applied immediately (asynchronous):
  - Count = 0, Empty = 1, Ready = 1.
  - Overflow = 0, Underflow = 0.
  - BusMuxIn = 0, both pointers = 0.
- Storage array is not reset.
- Push latency: a word accepted at edge N appears on `BusMuxIn` (if it is the head) and in `Count` immediately after edge N.
- Pop: `BusMuxIn` is valid combinationally during the cycle `RINout` is high. The bus captures it at edge N, the pointer advances at the same edge N, and the next word is visible after it.
- `Strobe` held high for k cycles pushes k words; the device must pulse it once per word.
- `Clear` asserted mid-burst discards all stored words. The first edge after deassertion behaves as from the empty state.

## Configuration
- `IN_PORT_STATUS_EN` defined: when `StatusOut` = 1, `BusMuxIn` is replaced by the status word.
  - Status word layout: bit0 Empty, bit1 Ready, bit2 Overflow, bit3 Underflow, bits [15:8] Count zero-extended, all other bits 0.
  - No pop occurs in that cycle even if `RINout` is also high.
  - `StatusOut` has priority over `RINout`.
- `IN_PORT_STATUS_EN` undefined: the `StatusOut` port does not exist and `BusMuxIn` always shows FIFO data.

## Structure
- Package `in_port_pkg`:
  - Status bit positions (`ST_EMPTY`, `ST_READY`, `ST_OVF`, `ST_UDF`).
  - Count field LSB/MSB (8/15).
  - Count-width helper function.
- Sub-module `fifo_ram`: DEPTH x DATA_WIDTH storage with one write port and one asynchronous read port, no reset.
- Pointers, Count, flags and the output mux stay in `in_port_fifo`.

## Test plan
- Reset then idle: Count = 0, Empty = 1, Ready = 1, BusMuxIn = 0, both flags 0.
- Push 0xA5A5_0001..0xA5A5_0003 over 3 cycles, then pop 3 times: BusMuxIn reads back in order; Count goes 3 -> 0; Empty = 1 after the third pop.
- DEPTH = 8: push 9 words without popping: Count = 8, Ready = 0, Overflow = 1. The 9th word is absent; the 8 pops return words 1..8.
- Full FIFO with simultaneous push of 0x1234 and pop: Count stays 8, Overflow stays 0, and 0x1234 is the last word popped.
- Empty FIFO with `RINout` and `Strobe`(0xBEEF) in the same cycle: Underflow = 1, Count = 1, BusMuxIn = 0xBEEF.
- With `IN_PORT_STATUS_EN`, Count = 3 and Overflow = 1: `StatusOut` + `RINout` -> BusMuxIn = 0x0000_0306 and Count stays 3. `Clear` mid-stream then resets all outputs.
